// File: rtl/arena_port_arbiter.sv
// arena_port_arbiter
// Shares the single read/write port of the arena map among player A,
// player B and the bomb engine. Each grant runs a 3-cycle transaction:
// IDLE (arbitrate) -> RD (read old code) -> CHK (check rule, maybe write).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   game_active               player requests eligible when 1
//   a/b/e_req, a/b/e_cell     requests and target cell (10*y + x)
//   a_op, b_op                player op: PROBE, CLAIM, FREE, BOMB
//   e_wdata                   engine write value (unconditional)
//   a/b/e_gnt, a/b/e_done     one-cycle grant / completion pulses
//   ok, old_code              result and old cell code, valid with done
//   map_addr, map_rd_en       map RAM address / read strobe
//   map_rdata                 map read data, 1-cycle latency
//   map_wr_en, map_wdata      map RAM write strobe / data
//   busy                      high while in RD or CHK
module arena_port_arbiter #(
  parameter int CELLS = 100,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          game_active,
  input  logic          a_req,
  input  logic          b_req,
  input  logic          e_req,
  input  logic [AW-1:0] a_cell,
  input  logic [AW-1:0] b_cell,
  input  logic [AW-1:0] e_cell,
  input  logic [1:0]    a_op,
  input  logic [1:0]    b_op,
  input  logic [1:0]    e_wdata,
  output logic          a_gnt,
  output logic          b_gnt,
  output logic          e_gnt,
  output logic          a_done,
  output logic          b_done,
  output logic          e_done,
  output logic          ok,
  output logic [1:0]    old_code,
  output logic [AW-1:0] map_addr,
  output logic          map_rd_en,
  input  logic [1:0]    map_rdata,
  output logic          map_wr_en,
  output logic [1:0]    map_wdata,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_CHK} state_t;
  typedef enum logic [1:0] {W_A, W_B, W_E} who_t;

  localparam logic [1:0] OP_PROBE = 2'd0;
  localparam logic [1:0] OP_CLAIM = 2'd1;
  localparam logic [1:0] OP_FREE  = 2'd2;
  localparam logic [1:0] OP_BOMB  = 2'd3;

  // One extra bit so the bound still fits when CELLS == 2**AW.
  localparam logic [AW:0] CELL_LIMIT = (AW+1)'(CELLS);

  state_t        r_state, w_state_next;
  who_t          r_win, w_win;
  logic [AW-1:0] r_cell, w_cell;
  logic [1:0]    r_op, w_op;
  logic [1:0]    r_wdata;
  logic          r_last_b;   // 1: B completed the most recent player transaction

  logic w_a_elig, w_b_elig, w_e_elig, w_any;
  logic w_legal, w_ok, w_wr;
  logic [1:0] w_wval;

  assign w_e_elig = e_req;
  assign w_a_elig = a_req & game_active;
  assign w_b_elig = b_req & game_active;
  assign w_any    = w_e_elig | w_a_elig | w_b_elig;
  assign w_legal  = ({1'b0, r_cell} < CELL_LIMIT);

  // Winner selection: engine first, then round-robin between the players.
  always_comb begin
    w_win = W_E;
    if (w_e_elig)                 w_win = W_E;
    else if (w_a_elig && w_b_elig) w_win = r_last_b ? W_A : W_B;
    else if (w_a_elig)            w_win = W_A;
    else                          w_win = W_B;
  end

  always_comb begin
    w_cell = e_cell;
    w_op   = OP_PROBE;
    case (w_win)
      W_A:     begin w_cell = a_cell; w_op = a_op; end
      W_B:     begin w_cell = b_cell; w_op = b_op; end
      default: begin w_cell = e_cell; w_op = OP_PROBE; end
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_next = S_RD;
      S_RD:    w_state_next = S_CHK;
      S_CHK:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_win    <= W_A;
      r_cell   <= '0;
      r_op     <= OP_PROBE;
      r_wdata  <= 2'd0;
      r_last_b <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && w_any) begin
        r_win   <= w_win;
        r_cell  <= w_cell;
        r_op    <= w_op;
        r_wdata <= e_wdata;
      end
      if (r_state == S_CHK && r_win != W_E)
        r_last_b <= (r_win == W_B);
    end
  end

  // Legality rule applied to the code read back during CHK.
  always_comb begin
    w_ok   = 1'b1;
    w_wr   = 1'b0;
    w_wval = 2'd0;
    if (r_win == W_E) begin
      w_wr   = 1'b1;
      w_wval = r_wdata;
    end else begin
      case (r_op)
        OP_CLAIM: begin
          w_ok   = (map_rdata == 2'd0);
          w_wr   = w_ok;
          w_wval = 2'd3;
        end
        OP_FREE: begin
          w_wr   = 1'b1;
          w_wval = 2'd0;
        end
        OP_BOMB: begin
          w_ok   = (map_rdata == 2'd0) || (map_rdata == 2'd3);
          w_wr   = w_ok;
          w_wval = 2'd2;
        end
        default: ;
      endcase
    end
    if (!w_legal) begin
      w_ok = 1'b0;
      w_wr = 1'b0;
    end
  end

  // Outputs decoded from state; reset forces them low in the same cycle so a
  // transaction caught in CHK neither writes nor reports done.
  always_comb begin
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    e_gnt     = 1'b0;
    a_done    = 1'b0;
    b_done    = 1'b0;
    e_done    = 1'b0;
    ok        = 1'b0;
    old_code  = 2'd0;
    map_addr  = '0;
    map_rd_en = 1'b0;
    map_wr_en = 1'b0;
    map_wdata = 2'd0;
    busy      = 1'b0;
    if (!rst) begin
      case (r_state)
        S_RD: begin
          a_gnt     = (r_win == W_A);
          b_gnt     = (r_win == W_B);
          e_gnt     = (r_win == W_E);
          map_addr  = r_cell;
          map_rd_en = w_legal;
          busy      = 1'b1;
        end
        S_CHK: begin
          a_done    = (r_win == W_A);
          b_done    = (r_win == W_B);
          e_done    = (r_win == W_E);
          ok        = w_ok;
          old_code  = w_legal ? map_rdata : 2'd0;
          map_addr  = r_cell;
          map_wr_en = w_wr;
          map_wdata = w_wr ? w_wval : 2'd0;
          busy      = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arena_port_arbiter.sv
// Testbench for arena_port_arbiter: requester agents obeying the handshake
// contract, a map RAM with 1-cycle read latency, and a transaction-level
// reference model that decides each grant and its outcome from the rules and
// a shadow copy of the arena.
module tb_arena_port_arbiter;
  localparam int CELLS = 100;
  localparam int AW    = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, game_active = 1'b1;
  logic          a_req = 0, b_req = 0, e_req = 0;
  logic [AW-1:0] a_cell = 0, b_cell = 0, e_cell = 0;
  logic [1:0]    a_op = 0, b_op = 0, e_wdata = 0;
  logic          a_gnt, b_gnt, e_gnt, a_done, b_done, e_done, ok;
  logic [1:0]    old_code, map_wdata;
  logic [AW-1:0] map_addr;
  logic          map_rd_en, map_wr_en, busy;
  logic [1:0]    ram_q = 2'd0;
  logic          mem_clr = 1'b1;

  arena_port_arbiter #(.CELLS(CELLS), .AW(AW)) dut (
    .clk(clk), .rst(rst), .game_active(game_active),
    .a_req(a_req), .b_req(b_req), .e_req(e_req),
    .a_cell(a_cell), .b_cell(b_cell), .e_cell(e_cell),
    .a_op(a_op), .b_op(b_op), .e_wdata(e_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .e_gnt(e_gnt),
    .a_done(a_done), .b_done(b_done), .e_done(e_done),
    .ok(ok), .old_code(old_code), .map_addr(map_addr), .map_rd_en(map_rd_en),
    .map_rdata(ram_q), .map_wr_en(map_wr_en), .map_wdata(map_wdata), .busy(busy)
  );

  // Arena storage as seen by the DUT.
  logic [1:0] ram [0:127];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 128; i++) ram[i] <= 2'd0;
      ram_q <= 2'd0;
    end else begin
      if (map_wr_en) ram[map_addr] <= map_wdata;
      if (map_rd_en) ram_q <= ram[map_addr];
    end
  end

  int n_vec = 0, n_err = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Agents (0 = A, 1 = B, 2 = E) and stimulus shadows, applied only in step().
  bit         pend [3];
  int         acell [3];
  logic [1:0] aop [3];
  int         drop_cyc [3];
  logic [1:0] ew = 2'd0;
  logic       ga_nxt = 1'b1;

  // Reference model.
  logic [1:0] ref_map [0:CELLS-1];
  bit         last_b = 1'b1;
  int         free_cyc = 0;
  bit         p_valid = 0;
  int         p_gnt_cyc, p_done_cyc, p_who, p_cell;
  bit         p_ok, p_wr, p_legal;
  logic [1:0] p_old, p_wdata;

  task automatic raise(input int i, input int c, input logic [1:0] o, input logic [1:0] w);
    if (!pend[i] && drop_cyc[i] < 0) begin
      pend[i] = 1; acell[i] = c; aop[i] = o;
      if (i == 2) ew = w;
    end
  endtask

  task automatic decide(input int c);
    bit ea, eb, ee;
    logic [1:0] old;
    ee = pend[2];
    ea = pend[0] && game_active;
    eb = pend[1] && game_active;
    if (!(ea || eb || ee)) return;
    if (ee) p_who = 2;
    else if (ea && eb) p_who = last_b ? 0 : 1;
    else p_who = ea ? 0 : 1;
    p_cell  = acell[p_who];
    p_legal = (p_cell < CELLS);
    old     = p_legal ? ref_map[p_cell] : 2'd0;
    p_old   = old;
    p_wdata = 2'd0;
    if (p_who == 2) begin
      p_ok = 1; p_wr = 1; p_wdata = ew;
    end else begin
      case (aop[p_who])
        2'd0: begin p_ok = 1; p_wr = 0; end
        2'd1: begin p_ok = (old == 0); p_wr = p_ok; p_wdata = 2'd3; end
        2'd2: begin p_ok = 1; p_wr = 1; p_wdata = 2'd0; end
        default: begin p_ok = (old == 0 || old == 3); p_wr = p_ok; p_wdata = 2'd2; end
      endcase
    end
    if (!p_legal) begin p_ok = 0; p_wr = 0; end
    if (!p_wr) p_wdata = 2'd0;
    p_valid    = 1;
    p_gnt_cyc  = c + 1;
    p_done_cyc = c + 2;
    free_cyc   = c + 3;
    drop_cyc[p_who] = c + 2;
  endtask

  task automatic step(input bit do_rst);
    logic [31:0] got, exp;
    string wn;
    @(posedge clk); #1;
    cyc++;
    for (int i = 0; i < 3; i++)
      if (drop_cyc[i] == cyc) begin pend[i] = 0; drop_cyc[i] = -1; end
    // A grant wiped out by reset is never seen, so the requester keeps asking.
    if (do_rst && p_valid && p_gnt_cyc == cyc) drop_cyc[p_who] = -1;
    rst = do_rst;
    game_active = ga_nxt;
    a_req = pend[0]; a_cell = AW'(acell[0]); a_op = aop[0];
    b_req = pend[1]; b_cell = AW'(acell[1]); b_op = aop[1];
    e_req = pend[2]; e_cell = AW'(acell[2]); e_wdata = ew;
    #1;
    got = {11'd0, a_gnt, b_gnt, e_gnt, a_done, b_done, e_done, ok, old_code,
           map_addr, map_rd_en, map_wr_en, map_wdata, busy};
    exp = 32'd0;
    if (!do_rst && p_valid && cyc == p_gnt_cyc)
      exp = {11'd0, p_who == 0, p_who == 1, p_who == 2, 3'b000, 1'b0, 2'd0,
             AW'(p_cell), p_legal, 1'b0, 2'd0, 1'b1};
    if (!do_rst && p_valid && cyc == p_done_cyc)
      exp = {11'd0, 3'b000, p_who == 0, p_who == 1, p_who == 2, p_ok, p_old,
             AW'(p_cell), 1'b0, p_wr, p_wdata, 1'b1};
    chk("outputs", got, exp);
    if (do_rst) begin
      p_valid = 0; last_b = 1; free_cyc = cyc + 1;
    end else begin
      if (p_valid && cyc == p_done_cyc) begin
        if (p_wr) ref_map[p_cell] = p_wdata;
        if (p_who != 2) last_b = (p_who == 1);
        wn = (p_who == 0) ? "A" : (p_who == 1) ? "B" : "E";
        $display("txn cyc=%0d who=%s cell=%0d ok=%0d old=%0d wr=%0d wdata=%0d",
                 cyc, wn, p_cell, p_ok, p_old, p_wr, p_wdata);
        p_valid = 0;
      end
      if (cyc >= free_cyc) decide(cyc);
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(1'b0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin pend[i] = 0; acell[i] = 0; aop[i] = 0; drop_cyc[i] = -1; end
    for (int i = 0; i < CELLS; i++) ref_map[i] = 2'd0;
    step(1); step(1); step(1);
    mem_clr = 1'b0;
    step(1);
    run(2);

    // CLAIM an empty cell, then a colliding CLAIM by B.
    raise(0, 23, 2'd1, 2'd0); run(4);
    raise(1, 23, 2'd1, 2'd0); run(4);
    // All three together: E, A, B.
    raise(0, 40, 2'd3, 2'd0); raise(1, 41, 2'd1, 2'd0); raise(2, 5, 2'd0, 2'd1); run(10);
    // Players only: alternate.
    raise(0, 50, 2'd1, 2'd0); raise(1, 51, 2'd1, 2'd0); run(4);
    raise(0, 52, 2'd1, 2'd0); run(7);
    // Players masked while game inactive; engine keeps being served.
    ga_nxt = 1'b0;
    raise(0, 60, 2'd1, 2'd0);
    for (int k = 0; k < 8; k++) begin raise(2, 61 + k, 2'd0, 2'd2); step(1'b0); end
    ga_nxt = 1'b1; run(8);
    // Illegal cell.
    raise(0, 100, 2'd1, 2'd0); run(4);
    raise(1, 109, 2'd2, 2'd0); run(4);
    // Reset during the CHK cycle of an engine write, then a player tie.
    raise(2, 7, 2'd0, 2'd2);
    step(1'b0); step(1'b0); step(1'b1); step(1'b0);
    raise(0, 70, 2'd1, 2'd0); raise(1, 71, 2'd1, 2'd0); run(8);

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 3) == 0)
          raise(i, int'($urandom_range(0, 109)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 19) == 0) ga_nxt = ~ga_nxt;
      step($urandom_range(0, 199) == 0);
    end
    for (int i = 0; i < 3; i++) pend[i] = 0;
    ga_nxt = 1'b1;
    run(6);

    for (int i = 0; i < CELLS; i++) chk("map", {30'd0, ram[i]}, {30'd0, ref_map[i]});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/arena_port_arbiter.md
# arena_port_arbiter

Shares the single read/write port of the 10x10 arena map (cells 0-99, 2-bit codes) among three requesters: player A control, player B control and the bomb engine. Each granted request runs a 3-cycle read-check-write transaction on the map RAM: it reads the old cell code, applies the legality rule for the operation and commits the write only if the rule passes. The block sits between `chara_control`/`bomb` and the arena storage, and is the only writer of that storage.

## Interface
Parameters:
- CELLS, 100, number of arena cells; addresses >= CELLS are illegal
- AW, 7, cell address width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- game_active  in  1  1 = player requests eligible; 0 = only the engine is served
- a_req / b_req / e_req  in  1  request from player A / player B / bomb engine
- a_cell / b_cell / e_cell  in  AW  target cell index (10*y + x)
- a_op / b_op  in  2  player op: 00 PROBE, 01 CLAIM, 10 FREE, 11 BOMB
- e_wdata  in  2  engine write value, written unconditionally
- a_gnt / b_gnt / e_gnt  out  1  one-cycle grant pulse
- a_done / b_done / e_done  out  1  one-cycle completion pulse
- ok  out  1  result of the transaction, valid with done
- old_code  out  2  cell code read, valid with done; 0 for illegal addresses
- map_addr  out  AW  map RAM address
- map_rd_en  out  1  map read strobe
- map_rdata  in  2  map read data, 1-cycle latency
- map_wr_en  out  1  map write strobe
- map_wdata  out  2  map write data
- busy  out  1  high while in RD or CHK

## Operation
- Cell codes: 0 empty, 1 wall, 2 bomb, 3 player.
- FSM states: IDLE, RD, CHK.
- **IDLE**
  - Evaluate eligible requests: e_req; a_req and b_req only when game_active = 1.
  - If any are eligible, latch the winner, cell, op and e_wdata, then go to RD.
- **Arbitration**
  - The engine always wins.
  - Between A and B: round-robin on last_player, which is updated only when a player transaction completes.
  - Reset sets last_player = B, so A wins the first tie.
- **RD**
  - Assert gnt of the winner.
  - map_rd_en = 1 if the cell is < CELLS.
  - Go to CHK.
- **CHK**
  - Assert done of the winner, plus ok and old_code.
  - If allowed, map_wr_en = 1 with map_wdata. Go to IDLE.
- **Rules** (old = map_rdata):
  - PROBE: ok = 1, no write.
  - CLAIM: ok = (old == 0), writes 3.
  - FREE: ok = 1, writes 0.
  - BOMB: ok = (old == 0 or old == 3), writes 2.
  - Engine: ok = 1, writes e_wdata.
- **Illegal cell** (>= CELLS): no read and no write; done with ok = 0 and old_code = 0.
- **Requester contract**
  - Hold req, cell and op stable until gnt is seen.
  - Deassert req by the cycle after gnt.
  - If req is still high in IDLE after done, it is a new request.
- **Mid-transaction changes**
  - game_active falling in RD/CHK does not abort a granted transaction.
  - Requests arriving while busy wait; they are not lost as long as req is held.

## Timing
- Arbitration decision in IDLE at cycle T.
- gnt, map_rd_en and map_addr at T+1.
- done, ok, old_code, map_wr_en and map_wdata at T+2.
- Earliest next arbitration at T+3, giving a throughput of 1 transaction per 3 cycles.
- map_addr holds the latched cell through RD and CHK; otherwise 0.
- Outputs are registered/state-decoded; gnt and done are never asserted together for the same requester.
- **Reset** (synchronous, any state)
  - State = IDLE, last_player = B.
  - All outputs 0: gnt, done, ok, old_code, map_addr, map_rd_en, map_wr_en, map_wdata, busy.
  - A transaction in flight is dropped: no write and no done.

## Test plan
- CLAIM to an empty cell: a_req, a_cell = 23, op CLAIM, map cell 23 = 0.
  - a_gnt at T+1.
  - a_done, ok = 1, old_code = 0, map_wr_en with wdata = 3 to addr 23 at T+2.
- Collision: b_req CLAIM cell 23, which holds 3.
  - ok = 0, old_code = 3, no map_wr_en.
- Simultaneous requests: a_req, b_req and e_req raised together and held.
  - Grant order E, A, B; gnt pulses at T+1, T+4, T+7.
  - Repeat A and B both held with no engine: grants alternate A, B, A.
- game_active = 0 with a_req and e_req held.
  - Only the engine is granted; A is granted 3 cycles after game_active returns to 1.
- Illegal cell: a_req, cell = 100.
  - a_done, ok = 0, old_code = 0, map_rd_en and map_wr_en never asserted.
- rst asserted in the CHK cycle of an engine write.
  - No map_wr_en and no e_done.
  - All outputs 0 on the next cycle; the next tie goes to A.
